// File: rtl/mma_cfg_pkg.sv
// rtl/mma_cfg_pkg.sv - GEMM job descriptor type, queue FSM states and descriptor check
package mma_cfg_pkg;

  localparam int MMA_REG_W = 32;

  typedef struct packed {
    logic [MMA_REG_W-1:0] lhs_base;
    logic [MMA_REG_W-1:0] rhs_base;
    logic [MMA_REG_W-1:0] dst_base;
    logic [MMA_REG_W-1:0] bias_base;
    logic [MMA_REG_W-1:0] lhs_zp;
    logic [MMA_REG_W-1:0] rhs_zp;
    logic [MMA_REG_W-1:0] dst_zp;
    logic [MMA_REG_W-1:0] q_mult_pt;
    logic [MMA_REG_W-1:0] q_shift_pt;
    logic [MMA_REG_W-1:0] k;
    logic [MMA_REG_W-1:0] n;
    logic [MMA_REG_W-1:0] m;
    logic [MMA_REG_W-1:0] lhs_row_stride_b;
    logic [MMA_REG_W-1:0] dst_row_stride_b;
    logic [MMA_REG_W-1:0] rhs_row_stride_b;
    logic [MMA_REG_W-1:0] act_min;
    logic [MMA_REG_W-1:0] act_max;
    logic                 use_per_channel;
    logic                 cfg_16bits_ia;
  } mma_desc_t;

  localparam int DESC_W = $bits(mma_desc_t);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, RUN} mma_state_e;

  // Clamp bounds are two's complement, so the ordering test must be signed.
  function automatic logic desc_valid(input mma_desc_t d);
    return (d.k != '0) && (d.n != '0) && (d.m != '0) &&
           !($signed(d.act_min) > $signed(d.act_max));
  endfunction

endpackage

// File: rtl/mma_cfg_queue_if.sv
// rtl/mma_cfg_queue_if.sv - push, core config and status signals of the job queue
interface mma_cfg_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  import mma_cfg_pkg::*;

  logic                   push_valid;
  logic                   push_ready;
  mma_desc_t              push_desc;
  logic                   flush;
  logic                   calc_start;
  mma_desc_t              cfg_desc;
  logic                   sa_ready;
  logic                   busy;
  logic [$clog2(DEPTH):0] q_count;
  logic                   job_done;
  logic                   err_cfg;
  logic                   err_timeout;
  logic [CNT_W-1:0]       done_cnt;

  modport slave (
    input  push_valid, push_desc, flush, sa_ready,
    output push_ready, calc_start, cfg_desc, busy, q_count,
           job_done, err_cfg, err_timeout, done_cnt
  );

  modport master (
    output push_valid, push_desc, flush, sa_ready,
    input  push_ready, calc_start, cfg_desc, busy, q_count,
           job_done, err_cfg, err_timeout, done_cnt
  );

endinterface

// File: rtl/mma_desc_fifo.sv
// rtl/mma_desc_fifo.sv - descriptor FIFO with full flush and keep-head flush
module mma_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  input  logic                   flush_all,
  input  logic                   flush_keep_head,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_wr, do_rd;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign rd_data = mem[rptr[AW-1:0]];
  assign do_wr   = wr_en && !full && !flush_all && !flush_keep_head;
  assign do_rd   = rd_en && !empty && !flush_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_all) begin
      wptr <= rptr;
    end else begin
      if (do_rd) rptr <= rptr + PTR_ONE;
      // The head stays; if it is popped in the same cycle the queue ends empty.
      if (flush_keep_head) wptr <= empty ? rptr : rptr + PTR_ONE;
      else if (do_wr)      wptr <= wptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mma_cfg_queue.sv
// rtl/mma_cfg_queue.sv - queues GEMM descriptors and issues them one by one to the MMA core
module mma_cfg_queue
  import mma_cfg_pkg::*;
#(
  parameter int REG_WIDTH   = 32,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst_n,
  mma_cfg_queue_if.slave bus
);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  if (REG_WIDTH != MMA_REG_W) begin : g_width_check
    $error("REG_WIDTH must match the descriptor field width");
  end

  mma_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q;
  mma_desc_t        head, cfg_q;
  logic             fifo_full, fifo_empty, in_flight;
  logic             push_fire, wr_en, pop, start_load;
  logic             calc_start, err_timeout, done_fire;
  logic             job_done_q, err_cfg_q;
  logic [CNT_W-1:0] done_cnt_q;

  assign in_flight      = (state_q != IDLE);
  assign bus.push_ready = !fifo_full && !bus.flush;
  assign push_fire      = bus.push_valid && bus.push_ready;
  assign wr_en          = push_fire && desc_valid(bus.push_desc);

  mma_desc_fifo #(.DEPTH(DEPTH), .W(DESC_W)) u_fifo (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_data         (bus.push_desc),
    .rd_en           (pop),
    .flush_all       (bus.flush && !in_flight),
    .flush_keep_head (bus.flush && in_flight),
    .rd_data         (head),
    .full            (fifo_full),
    .empty           (fifo_empty),
    .count           (bus.q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    start_load  = 1'b0;
    calc_start  = 1'b0;
    err_timeout = 1'b0;
    done_fire   = 1'b0;
    case (state_q)
      // Holding off one cycle after job_done spaces back-to-back starts by two cycles.
      IDLE: if (!fifo_empty && bus.sa_ready && !bus.flush && !job_done_q) begin
        start_load = 1'b1;
        state_d    = START;
      end
      START: begin
        calc_start = 1'b1;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: if (!bus.sa_ready) begin
        state_d = RUN;
      end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
        err_timeout = 1'b1;
        pop         = 1'b1;
        state_d     = IDLE;
      end
      RUN: if (bus.sa_ready) begin
        done_fire = 1'b1;
        pop       = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      cfg_q      <= '0;
      job_done_q <= 1'b0;
      err_cfg_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (state_q == START)         timer_q <= '0;
      else if (state_q == WAIT_ACK) timer_q <= timer_q + TW'(1);
      if (start_load) cfg_q <= head;
      job_done_q <= done_fire;
      err_cfg_q  <= push_fire && !desc_valid(bus.push_desc);
      if (done_fire) done_cnt_q <= done_cnt_q + CNT_W'(1);
    end
  end

  assign bus.calc_start  = calc_start;
  assign bus.cfg_desc    = cfg_q;
  assign bus.busy        = in_flight;
  assign bus.job_done    = job_done_q;
  assign bus.err_cfg     = err_cfg_q;
  assign bus.err_timeout = err_timeout;
  assign bus.done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_mma_cfg_queue.sv
// tb/tb_mma_cfg_queue.sv - scoreboard bench for the MMA descriptor queue
module tb_mma_cfg_queue;
  import mma_cfg_pkg::*;

  localparam int DEPTH = 4, ACK_TIMEOUT = 8, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mma_cfg_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mma_cfg_queue #(.REG_WIDTH(32), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mma_desc_t exp_start[$];
  int        exp_done[$];
  int        exp_err = 0, exp_to = 0;

  logic core_rdy = 1'b1;
  bit   stall = 1'b0, no_ack = 1'b0;
  int   rise_cyc = -100;
  assign bus.sa_ready = core_rdy && !stall;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void chk_desc(input string name, input mma_desc_t act, input mma_desc_t exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic mma_desc_t mk(input int base, input int k, input int n, input int m,
                                   input int amin, input int amax);
    mma_desc_t d = '0;
    d.lhs_base = base;          d.rhs_base = base + 'h100;
    d.dst_base = base + 'h200;  d.bias_base = base + 'h300;
    d.lhs_zp = 3;  d.rhs_zp = 5;  d.dst_zp = 7;
    d.q_mult_pt = base ^ 'h55;  d.q_shift_pt = 9;
    d.k = k;  d.n = n;  d.m = m;
    d.lhs_row_stride_b = k;  d.dst_row_stride_b = n;  d.rhs_row_stride_b = n * 2;
    d.act_min = amin;  d.act_max = amax;
    d.use_per_channel = base[4];  d.cfg_16bits_ia = k[0];
    return d;
  endfunction

  // Core model: acknowledges a start after 3 cycles and finishes 20 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.calc_start) begin
        if (no_ack) no_ack = 1'b0;
        else begin
          repeat (3) @(negedge clk);
          core_rdy = 1'b0;
          repeat (20) @(negedge clk);
          core_rdy = 1'b1;
          rise_cyc = cyc;
        end
      end
    end
  end

  mma_desc_t cur_desc = '0;
  int start_cyc = -100, done_cyc = -1, first_start_cyc = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.calc_start) begin
        chk("calc_start expected", exp_start.size() > 0, 1);
        if (exp_start.size() > 0) begin
          cur_desc = exp_start.pop_front();
          chk_desc("cfg_desc at start", bus.cfg_desc, cur_desc);
        end
        if (first_start_cyc >= 0) begin
          chk("start latency", cyc, first_start_cyc);
          first_start_cyc = -1;
        end
        if (done_cyc >= 0) chk("start gap after job_done", (cyc - done_cyc) >= 2, 1);
        start_cyc = cyc;
      end
      if (bus.busy) chk_desc("cfg_desc stable", bus.cfg_desc, cur_desc);
      if (bus.job_done) begin
        chk("job_done expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) chk("done_cnt at job_done", bus.done_cnt, exp_done.pop_front());
        chk("job_done latency", cyc, rise_cyc + 1);
        done_cyc = cyc;
      end
      if (bus.err_cfg) begin
        chk("err_cfg expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
      end
      if (bus.err_timeout) begin
        chk("err_timeout expected", exp_to > 0, 1);
        if (exp_to > 0) exp_to--;
        chk("timeout latency", cyc, start_cyc + ACK_TIMEOUT);
      end
    end
  end

  // Called at a falling edge; leaves the caller at the next falling edge.
  task automatic push(input mma_desc_t d, input bit exp_rdy);
    bus.push_valid = 1'b1;
    bus.push_desc  = d;
    #1;
    chk("push_ready", bus.push_ready, exp_rdy);
    @(negedge clk);
    bus.push_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_start.size() == 0 && exp_done.size() == 0 && !bus.busy &&
             bus.q_count == 0 && core_rdy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({"idle reached ", tag}, n < 2000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (bus.sa_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({"core ack ", tag}, n < 200, 1);
  endtask

  mma_desc_t d;

  initial begin
    bus.push_valid = 1'b0;
    bus.push_desc  = '0;
    bus.flush      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset push_ready", bus.push_ready, 1);
    chk("reset q_count", bus.q_count, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset calc_start", bus.calc_start, 0);
    chk("reset job_done", bus.job_done, 0);
    chk("reset err_cfg", bus.err_cfg, 0);
    chk("reset err_timeout", bus.err_timeout, 0);
    chk("reset done_cnt", bus.done_cnt, 0);
    chk_desc("reset cfg_desc", bus.cfg_desc, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job
    d = mk(32'h1000, 16, 8, 4, -128, 127);
    exp_start.push_back(d);
    exp_done.push_back(1);
    first_start_cyc = cyc + 2;
    push(d, 1'b1);
    wait_idle("single job");
    chk_desc("cfg_desc held in IDLE", bus.cfg_desc, d);
    chk("done_cnt after single", bus.done_cnt, 1);

    // Fill to DEPTH while the core is stalled
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = mk(32'h2000 + i * 16, 4 + i, 2, 2, 0, 255);
      exp_start.push_back(d);
      exp_done.push_back(2 + i);
      push(d, 1'b1);
    end
    chk("q_count full", bus.q_count, 4);
    push(mk(32'h2400, 9, 9, 9, 0, 1), 1'b0);
    chk("q_count after refused push", bus.q_count, 4);
    stall = 1'b0;
    wait_idle("fill");
    chk("done_cnt after fill", bus.done_cnt, 5);

    // Descriptor validation
    exp_err = 2;
    push(mk(32'h3000, 0, 8, 4, 0, 10), 1'b1);
    push(mk(32'h3100, 8, 8, 4, 10, -5), 1'b1);
    chk("q_count after rejects", bus.q_count, 0);
    d = mk(32'h3200, 1, 1, 1, -5, 10);
    exp_start.push_back(d);
    exp_done.push_back(6);
    push(d, 1'b1);
    d = mk(32'h3300, 2, 1, 1, 7, 7);
    exp_start.push_back(d);
    exp_done.push_back(7);
    push(d, 1'b1);
    wait_idle("validation");
    chk("err_cfg pulses outstanding", exp_err, 0);
    chk("done_cnt after validation", bus.done_cnt, 7);

    // Ack timeout, then the next job proceeds
    no_ack = 1'b1;
    exp_to = 1;
    d = mk(32'h4000, 3, 3, 3, 0, 5);
    exp_start.push_back(d);
    push(d, 1'b1);
    d = mk(32'h4100, 5, 3, 3, 0, 5);
    exp_start.push_back(d);
    exp_done.push_back(8);
    push(d, 1'b1);
    wait_idle("timeout");
    chk("err_timeout pulses outstanding", exp_to, 0);
    chk("done_cnt after timeout", bus.done_cnt, 8);

    // Flush while the head is running
    d = mk(32'h5000, 6, 6, 6, 0, 9);
    exp_start.push_back(d);
    exp_done.push_back(9);
    push(d, 1'b1);
    push(mk(32'h5100, 6, 6, 6, 0, 9), 1'b1);
    push(mk(32'h5200, 6, 6, 6, 0, 9), 1'b1);
    wait_run("flush");
    @(negedge clk);
    bus.flush      = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_desc  = mk(32'h5300, 6, 6, 6, 0, 9);
    #1;
    chk("push_ready during flush", bus.push_ready, 0);
    @(negedge clk);
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    chk("q_count after flush", bus.q_count, 1);
    wait_idle("flush");
    repeat (10) @(negedge clk);
    chk("done_cnt after flush", bus.done_cnt, 9);

    // Reset while running
    d = mk(32'h6000, 4, 4, 4, 0, 3);
    exp_start.push_back(d);
    push(d, 1'b1);
    wait_run("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset mid-run calc_start", bus.calc_start, 0);
    chk("reset mid-run busy", bus.busy, 0);
    chk("reset mid-run q_count", bus.q_count, 0);
    chk("reset mid-run done_cnt", bus.done_cnt, 0);
    chk("reset mid-run job_done", bus.job_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("done_cnt after reset", bus.done_cnt, 0);
    chk("busy after reset", bus.busy, 0);
    chk("pending calc_start", exp_start.size(), 0);
    chk("pending job_done", exp_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
